// File: rtl/sha1_ctrl_pkg.sv
// Shared types and sizes for the SHA-1 core arbiter slice.
package sha1_ctrl_pkg;

  localparam int unsigned BLOCK_WORDS  = 16;
  localparam int unsigned DIGEST_WORDS = 5;
  localparam int unsigned NUM_REQ      = 2;

  typedef logic [BLOCK_WORDS-1:0][31:0]  block_t;
  typedef logic [DIGEST_WORDS-1:0][31:0] digest_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StFlush,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic [0:0] last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last[0] ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sha1_core_arbiter.sv
// Shares one external SHA-1 core between two requesters, with a completion
// timeout that flushes the core and reports a zero digest.
module sha1_core_arbiter
  import sha1_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [BLOCK_WORDS-1:0][31:0]  req_block0,
  input  logic [BLOCK_WORDS-1:0][31:0]  req_block1,
  output logic [1:0]                    rsp_valid,
  input  logic [1:0]                    rsp_ready,
  output logic [DIGEST_WORDS-1:0][31:0] rsp_digest,
  output logic                          rsp_timeout,
  output logic                          core_start,
  output logic [BLOCK_WORDS-1:0][31:0]  core_block,
  input  logic [DIGEST_WORDS-1:0][31:0] core_digest,
  input  logic                          core_done,
  output logic                          core_rst_n,
  output logic                          busy
);

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        flush_q, flush_d;
  logic        timeout_q, timeout_d;
  logic [15:0] cnt_q, cnt_d;
  block_t      block_q, block_d;
  digest_t     digest_q, digest_d;
  logic [1:0]  grant;

  rr_arbiter2 u_arb (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      flush_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      block_q   <= '0;
      digest_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      block_q   <= block_d;
      digest_q  <= digest_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    flush_d   = flush_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    block_d   = block_q;
    digest_d  = digest_q;
    case (state_q)
      StIdle: begin
        if (|grant) begin
          owner_d = grant[1];
          block_d = grant[1] ? req_block1 : req_block0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        // Completion takes priority over a timeout landing in the same cycle.
        if (core_done) begin
          digest_d  = core_digest;
          timeout_d = 1'b0;
          state_d   = StResp;
        end else if (cnt_q == TimeoutCnt) begin
          flush_d = 1'b0;
          state_d = StFlush;
        end
      end
      StFlush: begin
        digest_d  = '0;
        timeout_d = 1'b1;
        flush_d   = ~flush_q;
        if (flush_q) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready[owner_q]) begin
          last_d  = owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced to their reset values for the whole time reset_n is low.
  always_comb begin
    req_ready   = (reset_n && state_q == StIdle) ? grant : 2'b00;
    rsp_valid   = (reset_n && state_q == StResp) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    rsp_digest  = reset_n ? digest_q : '0;
    rsp_timeout = reset_n & timeout_q;
    core_start  = reset_n & (state_q == StIssue);
    core_block  = reset_n ? block_q : '0;
    core_rst_n  = reset_n & (state_q != StFlush);
    busy        = reset_n & (state_q != StIdle);
  end

endmodule

// File: tb/tb_sha1_core_arbiter.sv
// Scoreboard bench for sha1_core_arbiter with a behavioural stand-in for the SHA-1 core.
module tb_sha1_core_arbiter;
  import sha1_ctrl_pkg::*;

  typedef struct {
    logic [1:0] owner;
    digest_t    digest;
    logic       timeout;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] rsp_ready = 2'b00;
  block_t     req_block0 = '0;
  block_t     req_block1 = '0;
  digest_t    core_digest = '0;
  logic       core_done;
  logic       model_done = 1'b0;
  logic [1:0] req_ready, rsp_valid;
  digest_t    rsp_digest;
  logic       rsp_timeout, core_start, core_rst_n, busy;
  block_t     core_block;

  sha1_core_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_block0  (req_block0),
    .req_block1  (req_block1),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_digest  (rsp_digest),
    .rsp_timeout (rsp_timeout),
    .core_start  (core_start),
    .core_block  (core_block),
    .core_digest (core_digest),
    .core_done   (core_done),
    .core_rst_n  (core_rst_n),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;
  exp_t exp_q[$];
  exp_t e;
  block_t  abc_blk;
  digest_t abc_dig;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic block_t mk_block(input int unsigned seed);
    block_t b;
    for (int i = 0; i < 16; i++) b[i] = seed * 32'h01010101 + 32'(i) * 32'h11;
    return b;
  endfunction

  // Stand-in core result for non-"abc" blocks.
  function automatic digest_t digest_of(input block_t b);
    digest_t d;
    if (b == abc_blk) d = abc_dig;
    else for (int i = 0; i < 5; i++) d[i] = b[i] ^ b[i+5] ^ 32'hC3D2E1F0;
    return d;
  endfunction

  task automatic push(input logic [1:0] o, input digest_t d, input logic t);
    exp_t x;
    x.owner = o;
    x.digest = d;
    x.timeout = t;
    exp_q.push_back(x);
  endtask

  // Core model: done pulses core_delay cycles after the start cycle; 0 = never.
  int core_delay = 3, core_k = 0, done_cyc = -1, spur_req = 0, spur_ack = 0;
  logic core_run = 1'b0;
  block_t core_blk = '0;
  assign core_done = model_done;

  always @(negedge clk) begin
    model_done = 1'b0;
    if (spur_req != spur_ack) begin
      spur_ack = spur_req;
      model_done = 1'b1;
      core_digest = {5{32'hBAD0BAD0}};
    end else if (!core_rst_n) begin
      core_run = 1'b0;
    end else if (core_start) begin
      core_run = 1'b1;
      core_k = 0;
      core_blk = core_block;
    end else if (core_run) begin
      core_k++;
      if (core_delay != 0 && core_k == core_delay) begin
        model_done = 1'b1;
        core_run = 1'b0;
        core_digest = digest_of(core_blk);
        done_cyc = cyc;
      end
    end
  end

  // Monitor: pops the scoreboard on every response handshake.
  int acc_cyc = -100, start_cnt = 0, flush_cnt = 0, rv_cnt = 0, rv_rise = -1, rsp_cnt = 0;
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (|(req_valid & req_ready)) acc_cyc = cyc;
      if (core_start) begin
        start_cnt++;
        chk("start_latency", cyc, acc_cyc + 1);
      end
      if (!core_rst_n) flush_cnt++;
      if (rsp_valid != 2'b00) begin
        rv_cnt++;
        if (!rv_prev) rv_rise = cyc;
      end
      rv_prev = (rsp_valid != 2'b00);
      if (|(rsp_valid & rsp_ready)) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 2'b00);
        else begin
          e = exp_q.pop_front();
          chk("rsp_owner", rsp_valid, e.owner);
          chk("rsp_digest", rsp_digest, e.digest);
          chk("rsp_timeout", rsp_timeout, e.timeout);
        end
        rsp_cnt++;
      end
    end else rv_prev = 1'b0;
  end

  task automatic wait_rsp(input int n);
    int start = rsp_cnt;
    int budget = 200;
    while (rsp_cnt < start + n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("rsp_count", rsp_cnt - start, n);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_digest", rsp_digest, 160'd0);
    chk("rst_core_block", core_block, 512'd0);
    chk("rst_core_rst_n", core_rst_n, 1'b0);
  endtask

  task automatic one_shot(input logic [1:0] v);
    req_valid = v;
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  initial begin
    int s0, f0, r0, b;
    logic [191:0] snap;
    abc_blk = '0;
    abc_blk[0] = 32'h61626380;
    abc_blk[15] = 32'h00000018;
    abc_dig[0] = 32'hA9993E36;
    abc_dig[1] = 32'h4706816A;
    abc_dig[2] = 32'hBA3E2571;
    abc_dig[3] = 32'h7850C26C;
    abc_dig[4] = 32'h9CD0D89D;

    // Reset with both requesters asking: nothing may be granted.
    reset_n = 1'b0;
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    req_valid = 2'b00;
    reset_n = 1'b1;
    rsp_ready = 2'b11;
    @(negedge clk);

    // Both requesting for four jobs: 0,1,0,1.
    req_block0 = mk_block(1);
    req_block1 = mk_block(2);
    for (int i = 0; i < 4; i++)
      push((i % 2 == 1) ? 2'b10 : 2'b01, digest_of((i % 2 == 1) ? req_block1 : req_block0), 1'b0);
    req_valid = 2'b11;
    wait_rsp(4);
    req_valid = 2'b00;

    // "abc" from requester 0.
    s0 = start_cnt;
    req_block0 = abc_blk;
    push(2'b01, abc_dig, 1'b0);
    one_shot(2'b01);
    wait_rsp(1);
    chk("abc_starts", start_cnt - s0, 1);
    chk("abc_rsp_latency", rv_rise, done_cyc + 1);

    // Core never finishes: flush then timed-out response.
    core_delay = 0;
    f0 = flush_cnt;
    req_block1 = mk_block(3);
    push(2'b10, '0, 1'b1);
    one_shot(2'b10);
    wait_rsp(1);
    chk("timeout_flush_cycles", flush_cnt - f0, 2);

    // Done lands on the timeout cycle: real digest, no flush.
    core_delay = 9;
    f0 = flush_cnt;
    req_block0 = mk_block(4);
    push(2'b01, digest_of(req_block0), 1'b0);
    one_shot(2'b01);
    wait_rsp(1);
    chk("coincide_flush_cycles", flush_cnt - f0, 0);
    core_delay = 3;

    // Response held off, spurious done, competing request, non-owner ready.
    rsp_ready = 2'b00;
    req_block0 = mk_block(5);
    push(2'b01, digest_of(req_block0), 1'b0);
    one_shot(2'b01);
    b = 0;
    while (rsp_valid == 2'b00 && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("hold_rsp_valid", rsp_valid, 2'b01);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    snap = {rsp_valid, rsp_timeout, rsp_digest};
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) spur_req++;
      @(negedge clk);
      chk("hold_rsp_stable", {rsp_valid, rsp_timeout, rsp_digest}, snap);
      chk("hold_no_grant", req_ready, 2'b00);
    end
    chk("hold_no_start", start_cnt - s0, 0);
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    wait_rsp(1);
    rsp_ready = 2'b11;

    // One-cycle reset during WAIT abandons the job.
    core_delay = 0;
    req_block0 = mk_block(6);
    one_shot(2'b01);
    repeat (3) @(negedge clk);
    chk("wait_busy", busy, 1'b1);
    reset_n = 1'b0;
    #2;
    chk_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    r0 = rv_cnt;
    repeat (15) @(negedge clk);
    chk("abandon_no_rsp", rv_cnt - r0, 0);
    core_delay = 3;
    req_block0 = mk_block(7);
    push(2'b01, digest_of(req_block0), 1'b0);
    one_shot(2'b01);
    wait_rsp(1);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sha1_core_arbiter.md
SHA1_CORE_ARBITER -- requirements
Module: sha1_core_arbiter

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles to wait for core_done after core_start.
REQ-002 The module SHALL have the port clk, input, 1 bit, the clock; all logic is on its rising edge.
REQ-003 The module SHALL have the port reset_n, input, 1 bit, the reset: synchronous, active-low.
REQ-004 The module SHALL have the port req_valid, input, 2 bits, a per-requester block request.
REQ-005 The module SHALL have the port req_ready, output, 2 bits, a per-requester accept.
REQ-006 The module SHALL have the ports req_block0 and req_block1, input, 16x32 bits each (index 0 = first word), the message blocks.
REQ-007 The module SHALL have the port rsp_valid, output, 2 bits, a per-requester result-valid flag.
REQ-008 The module SHALL have the port rsp_ready, input, 2 bits, a per-requester result accept.
REQ-009 The module SHALL have the port rsp_digest, output, 5x32 bits, the shared digest (index 0 = H0).
REQ-010 The module SHALL have the port rsp_timeout, output, 1 bit, the timeout flag qualifying rsp_valid.
REQ-011 The module SHALL have the port core_start, output, 1 bit, the single-cycle start pulse to the SHA-1 core.
REQ-012 The module SHALL have the port core_block, output, 16x32 bits, a registered block driven to the core.
REQ-013 The module SHALL have the ports core_digest, input, 5x32 bits, and core_done, input, 1 bit, the core result and completion flag.
REQ-014 The module SHALL have the port core_rst_n, output, 1 bit, the active-low core reset.
REQ-015 The module SHALL have the port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT, FLUSH and RESP.
REQ-017 In IDLE with any req_valid, the arbiter SHALL grant round-robin: the requester not last served wins a tie, and a lone requester always wins.
REQ-018 In IDLE, req_ready SHALL be asserted combinationally, one-hot, for the granted requester only; it SHALL be 0 in all other states.
REQ-019 On acceptance (req_valid & req_ready), the module SHALL latch the granted block into core_block, record the owner, and enter ISSUE.
REQ-020 ISSUE SHALL assert core_start for exactly one cycle (acceptance cycle T, start at T+1), clear the timeout counter, and enter WAIT.
REQ-021 WAIT SHALL increment the 16-bit counter each cycle; on core_done, it SHALL latch core_digest and clear rsp_timeout.
REQ-022 When core_done and counter==TIMEOUT_CYCLES occur in the same cycle, core_done SHALL win.
REQ-023 When counter==TIMEOUT_CYCLES without core_done, the module SHALL enter FLUSH.
REQ-024 FLUSH SHALL drive core_rst_n low for exactly 2 cycles, set rsp_digest to all-zero and rsp_timeout=1, then enter RESP.
REQ-025 The module SHALL drive core_rst_n as reset_n AND (state != FLUSH).
REQ-026 RESP SHALL hold rsp_valid[owner] high, with rsp_digest and rsp_timeout stable, until rsp_ready[owner]=1.
REQ-027 On that handshake, the module SHALL update the last-served pointer to owner and return to IDLE; a new grant is possible in the next cycle.
REQ-028 core_done in IDLE, ISSUE, FLUSH or RESP SHALL be ignored.
REQ-029 rsp_ready in any state other than RESP, or for the non-owner, SHALL be ignored.
REQ-030 Latency SHALL be core_done at cycle D -> rsp_valid at D+1.
REQ-031 A requester dropping req_valid before acceptance SHALL lose its grant without side effects.

Reset
REQ-032 While reset_n=0, the module SHALL go to state IDLE, with last-served pointer = requester 1 (so requester 0 wins the first tie) and counter=0.
REQ-033 While reset_n=0, the outputs req_ready, rsp_valid, rsp_timeout, core_start and busy SHALL be 0.
REQ-034 While reset_n=0, the outputs rsp_digest and core_block SHALL be all-zero and core_rst_n SHALL be 0.
REQ-035 A reset mid-operation (any state) SHALL abandon the job without emitting a response.

Structure
REQ-036 The package sha1_ctrl_pkg SHALL hold the state enum, BLOCK_WORDS=16, DIGEST_WORDS=5, NUM_REQ=2, and the block/digest array typedefs.
REQ-037 Grant logic SHALL be the sub-module rr_arbiter2 (inputs: req[1:0], last[0:0]; output: one-hot grant[1:0]).
REQ-038 The SHA-1 core SHALL be external, connected through the core_* ports.

Verification
REQ-039 The bench SHALL cover: req_block0 = "abc" padded (w0=0x61626380, w1..w14=0, w15=0x00000018), req0 only -> one core_start at T+1, then rsp_valid[0] with digest A9993E36 4706816A BA3E2571 7850C26C 9CD0D89D and rsp_timeout=0.
REQ-040 The bench SHALL cover: req_valid=2'b11 held for 4 jobs -> grant order 0,1,0,1 with rsp_valid one-hot matching each owner.
REQ-041 The bench SHALL cover: core model never asserting done, TIMEOUT_CYCLES=8 -> core_rst_n low 2 cycles, then rsp_valid with rsp_timeout=1 and digest 0.
REQ-042 The bench SHALL cover: core_done coinciding with the timeout cycle -> real digest returned, rsp_timeout=0, and no FLUSH.
REQ-043 The bench SHALL cover: rsp_ready withheld 10 cycles, with a spurious core_done pulse and req_valid[1]=1 -> rsp outputs stable, no grant, and no second start.
REQ-044 The bench SHALL cover: reset_n=0 for 1 cycle during WAIT -> all outputs at reset values, no rsp_valid, and the next request is served normally.
